// File: rtl/urna_apuracao.sv
// Result-tally stage for the Urna voting core: snapshots the vote counters on a
// rising finish, computes winner/total, steps the display slots, then holds.
module urna_apuracao #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SHOW_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             finish,
  input  logic [CNT_W-1:0] contadorC1,
  input  logic [CNT_W-1:0] contadorC2,
  input  logic [CNT_W-1:0] contadorNull,
  output logic [1:0]       winner,
  output logic [CNT_W+1:0] total,
  output logic             result_valid,
  output logic [1:0]       disp_sel,
  output logic [CNT_W+1:0] disp_value,
  output logic             done
);

  localparam int unsigned DW_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_LOAD = DW_W'(SHOW_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_COMPARE,
    S_SHOW_C1,
    S_SHOW_C2,
    S_SHOW_NULL,
    S_SHOW_TOT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             finish_q;
  logic             armed_q;
  logic [CNT_W-1:0] c1_q, c1_d;
  logic [CNT_W-1:0] c2_q, c2_d;
  logic [CNT_W-1:0] null_q, null_d;
  logic [1:0]       winner_q, winner_d;
  logic [CNT_W+1:0] total_q, total_d;
  logic             valid_q, valid_d;
  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic             rise;

  // armed_q blocks a level that is already high when reset releases from
  // counting as a rise; finish must be sampled low first.
  assign rise = finish & ~finish_q & armed_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      finish_q <= 1'b0;
      armed_q  <= 1'b0;
      c1_q     <= '0;
      c2_q     <= '0;
      null_q   <= '0;
      winner_q <= '0;
      total_q  <= '0;
      valid_q  <= 1'b0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      finish_q <= finish;
      armed_q  <= armed_q | ~finish;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      null_q   <= null_d;
      winner_q <= winner_d;
      total_q  <= total_d;
      valid_q  <= valid_d;
      dwell_q  <= dwell_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    null_d     = null_q;
    winner_d   = winner_q;
    total_d    = total_q;
    valid_d    = valid_q;
    dwell_d    = dwell_q;
    disp_sel   = 2'b00;
    disp_value = '0;

    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_LATCH;
      end

      S_LATCH: begin
        c1_d    = contadorC1;
        c2_d    = contadorC2;
        null_d  = contadorNull;
        state_d = S_COMPARE;
      end

      S_COMPARE: begin
        if (c1_q > c2_q)       winner_d = 2'b01;
        else if (c2_q > c1_q)  winner_d = 2'b10;
        else if (c1_q == '0)   winner_d = 2'b00;
        else                   winner_d = 2'b11;
        total_d = {2'b00, c1_q} + {2'b00, c2_q} + {2'b00, null_q};
        valid_d = 1'b1;
        dwell_d = DW_LOAD;
        state_d = S_SHOW_C1;
      end

      S_SHOW_C1, S_SHOW_C2, S_SHOW_NULL, S_SHOW_TOT: begin
        case (state_q)
          S_SHOW_C1: begin
            disp_sel   = 2'b00;
            disp_value = {2'b00, c1_q};
          end
          S_SHOW_C2: begin
            disp_sel   = 2'b01;
            disp_value = {2'b00, c2_q};
          end
          S_SHOW_NULL: begin
            disp_sel   = 2'b10;
            disp_value = {2'b00, null_q};
          end
          default: begin
            disp_sel   = 2'b11;
            disp_value = total_q;
          end
        endcase

        if (dwell_q == '0) begin
          dwell_d = DW_LOAD;
          case (state_q)
            S_SHOW_C1:   state_d = S_SHOW_C2;
            S_SHOW_C2:   state_d = S_SHOW_NULL;
            S_SHOW_NULL: state_d = S_SHOW_TOT;
            default: begin
              state_d = S_DONE;
              dwell_d = '0;
            end
          endcase
        end else begin
          dwell_d = dwell_q - DW_W'(1);
        end
      end

      S_DONE: begin
        disp_sel   = 2'b11;
        disp_value = total_q;
        if (!finish) begin
          state_d  = S_IDLE;
          winner_d = '0;
          total_d  = '0;
          valid_d  = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign winner       = winner_q;
  assign total        = total_q;
  assign result_valid = valid_q;
  assign done         = (state_q == S_DONE);

endmodule
